// File: rtl/leaf_axis_adapter.sv
// leaf_axis_adapter: bridges a leaf valid/ack interface to AXI-Stream in both
// directions. Receive side is a first-word-fall-through FIFO feeding m_axis;
// transmit side is a single holding register draining s_axis to the leaf.
// A rising edge of ap_start flushes both paths and the word counters.
// Optional macro LEAF_AXIS_TLAST_EN adds a beat counter that marks the last
// beat of each pkt_len-beat packet on m_axis_tlast.
module leaf_axis_adapter #(
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic [15:0]             pkt_len,
    input  logic [PAYLOAD_BITS-1:0] din_interface2user,
    input  logic                    vld_interface2user,
    output logic                    ack_user2interface,
    output logic [PAYLOAD_BITS-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    input  logic [PAYLOAD_BITS-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [PAYLOAD_BITS-1:0] dout_user2interface,
    output logic                    vld_user2interface,
    input  logic                    ack_interface2user,
    output logic [31:0]             rx_count,
    output logic [31:0]             tx_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned CNT_W = 32;

    logic [PAYLOAD_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [OCC_W-1:0]        occupancy;

    logic                    tx_full;
    logic [PAYLOAD_BITS-1:0] tx_hold;

    logic [CNT_W-1:0]        rx_cnt;
    logic [CNT_W-1:0]        tx_cnt;

    logic                    start_q1;
    logic                    start_q2;
    logic                    flush_q;
    logic [LEN_W-1:0]        pkt_len_q;

    logic                    rx_push;
    logic                    rx_pop;
    logic                    tx_load;
    logic                    tx_deliver;

    // Handshake decode; ack and tvalid depend only on registered occupancy
    assign ack_user2interface  = (occupancy < OCC_W'(FIFO_DEPTH));
    assign m_axis_tvalid       = (occupancy != '0);
    assign m_axis_tdata        = fifo_mem[rd_ptr];
    assign rx_push             = vld_interface2user && ack_user2interface;
    assign rx_pop              = m_axis_tvalid && m_axis_tready;

    // Transmit side may accept a new word in the same cycle the old one leaves
    assign s_axis_tready       = !tx_full || ack_interface2user;
    assign tx_load             = s_axis_tvalid && s_axis_tready;
    assign tx_deliver          = tx_full && ack_interface2user;
    assign vld_user2interface  = tx_full;
    assign dout_user2interface = tx_hold;

    assign rx_count            = rx_cnt;
    assign tx_count            = tx_cnt;

    // ap_start rising-edge detect with a registered flush pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q1 <= 1'b0;
            start_q2 <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            start_q1 <= ap_start;
            start_q2 <= start_q1;
            flush_q  <= start_q1 && !start_q2;
        end
    end

    // Packet length captured at each flush
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_len_q <= '0;
        end else if (flush_q) begin
            pkt_len_q <= pkt_len;
        end
    end

    // Receive FIFO pointers and occupancy; flush wins over any transfer
    always_ff @(posedge clk) begin
        if (reset || flush_q) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (rx_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Receive FIFO storage; contents need no reset since occupancy gates them
    always_ff @(posedge clk) begin
        if (rx_push && !flush_q && !reset) begin
            fifo_mem[wr_ptr] <= din_interface2user;
        end
    end

    // Transmit full flag: a load in the same cycle as delivery keeps it set
    always_ff @(posedge clk) begin
        if (reset || flush_q) begin
            tx_full <= 1'b0;
        end else if (tx_load) begin
            tx_full <= 1'b1;
        end else if (tx_deliver) begin
            tx_full <= 1'b0;
        end
    end

    // Transmit holding register
    always_ff @(posedge clk) begin
        if (tx_load && !flush_q && !reset) begin
            tx_hold <= s_axis_tdata;
        end
    end

    // Word counters, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset || flush_q) begin
            rx_cnt <= '0;
            tx_cnt <= '0;
        end else begin
            if (rx_push) begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
            if (tx_deliver) begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

`ifdef LEAF_AXIS_TLAST_EN
    logic [LEN_W-1:0] beat_cnt;
    logic             beat_last;

    // A zero packet length never marks a last beat
    assign beat_last    = (pkt_len_q != '0) && (beat_cnt == (pkt_len_q - LEN_W'(1)));
    assign m_axis_tlast = m_axis_tvalid && beat_last;

    // Beat counter advances on every pop and restarts after the last beat
    always_ff @(posedge clk) begin
        if (reset || flush_q) begin
            beat_cnt <= '0;
        end else if (rx_pop) begin
            if (beat_last) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + LEN_W'(1);
            end
        end
    end
`else
    logic unused_pkt_len_q;

    assign m_axis_tlast     = 1'b0;
    assign unused_pkt_len_q = ^pkt_len_q;
`endif

endmodule

// File: tb/tb_leaf_axis_adapter.sv
// Bench for leaf_axis_adapter: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based model of the adapter.
module tb_leaf_axis_adapter;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ap_start;
    logic [15:0]   pkt_len;
    logic [W-1:0]  din_interface2user;
    logic          vld_interface2user;
    logic          ack_user2interface;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  dout_user2interface;
    logic          vld_user2interface;
    logic          ack_interface2user;
    logic [31:0]   rx_count;
    logic [31:0]   tx_count;

    leaf_axis_adapter #(.PAYLOAD_BITS(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .ap_start            (ap_start),
        .pkt_len             (pkt_len),
        .din_interface2user  (din_interface2user),
        .vld_interface2user  (vld_interface2user),
        .ack_user2interface  (ack_user2interface),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .m_axis_tlast        (m_axis_tlast),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .dout_user2interface (dout_user2interface),
        .vld_user2interface  (vld_user2interface),
        .ack_interface2user  (ack_interface2user),
        .rx_count            (rx_count),
        .tx_count            (tx_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0]  fifo_q[$];
    logic          full_m;
    logic [W-1:0]  hold_m;
    logic [31:0]   rx_m;
    logic [31:0]   tx_m;
    int            beat_m;
    int            len_m;
    logic          h1, h2, h3;
    logic          chk_en;

    // Observations from the most recent tick, used by directed steps
    logic          obs_pop;
    logic [W-1:0]  obs_data;
    logic          obs_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    task automatic tick();
        logic e_ack, e_tv, e_tl, e_str, push, pop, load, deliv, flush;
        #1;
        e_ack = (fifo_q.size() < DEPTH);
        e_tv  = (fifo_q.size() != 0);
`ifdef LEAF_AXIS_TLAST_EN
        e_tl  = e_tv && (len_m != 0) && (beat_m + 1 == len_m);
`else
        e_tl  = 1'b0;
`endif
        e_str = !full_m || ack_interface2user;
        if (chk_en) begin
            check("ack", 64'(ack_user2interface), 64'(e_ack));
            check("tvalid", 64'(m_axis_tvalid), 64'(e_tv));
            check("tlast", 64'(m_axis_tlast), 64'(e_tl));
            check("s_tready", 64'(s_axis_tready), 64'(e_str));
            check("vld_out", 64'(vld_user2interface), 64'(full_m));
            check("rx_count", 64'(rx_count), 64'(rx_m));
            check("tx_count", 64'(tx_count), 64'(tx_m));
            if (e_tv) check("tdata", 64'(m_axis_tdata), 64'(fifo_q[0]));
            if (full_m) check("dout", 64'(dout_user2interface), 64'(hold_m));
        end
        obs_pop  = m_axis_tvalid && m_axis_tready;
        obs_data = m_axis_tdata;
        obs_last = m_axis_tlast;
        push  = vld_interface2user && e_ack;
        pop   = e_tv && m_axis_tready;
        load  = s_axis_tvalid && e_str;
        deliv = full_m && ack_interface2user;
        flush = h2 && !h3;
        @(posedge clk);
        if (reset) begin
            fifo_q.delete();
            full_m = 1'b0;
            rx_m = '0;
            tx_m = '0;
            beat_m = 0;
            len_m = 0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            if (flush) begin
                fifo_q.delete();
                full_m = 1'b0;
                rx_m = '0;
                tx_m = '0;
                beat_m = 0;
                len_m = int'(pkt_len);
            end else begin
                if (pop) begin
                    beat_m = e_tl ? 0 : (beat_m + 1) % 65536;
                    void'(fifo_q.pop_front());
                end
                if (push) fifo_q.push_back(din_interface2user);
                if (push) rx_m = rx_m + 32'd1;
                if (deliv) tx_m = tx_m + 32'd1;
                if (load) begin
                    full_m = 1'b1;
                    hold_m = s_axis_tdata;
                end else if (deliv) begin
                    full_m = 1'b0;
                end
            end
            h3 = h2; h2 = h1; h1 = ap_start;
        end
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w [5];
        logic [W-1:0] got [5];
        int idx, npop, k;
        logic acc;

        w[0] = 32'h11; w[1] = 32'h12; w[2] = 32'h13; w[3] = 32'h14; w[4] = 32'h15;
        reset = 1'b1; ap_start = 1'b0; pkt_len = 16'd0;
        din_interface2user = '0; vld_interface2user = 1'b0;
        m_axis_tready = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        ack_interface2user = 1'b0;
        fifo_q.delete(); full_m = 1'b0; hold_m = '0; rx_m = '0; tx_m = '0;
        beat_m = 0; len_m = 0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        chk_en = 1'b0;
        @(negedge clk);

        // Reset values
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_ack", 64'(ack_user2interface), 64'd1);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd1);
        check("rst_vld_out", 64'(vld_user2interface), 64'd0);
        check("rst_rx", 64'(rx_count), 64'd0);
        check("rst_tx", 64'(tx_count), 64'd0);

        // Receive burst into a stalled stream: four accepted, fifth held
        idx = 0;
        vld_interface2user = 1'b1;
        for (int c = 0; c < 8; c++) begin
            din_interface2user = w[idx];
            acc = (fifo_q.size() < DEPTH);
            tick();
            if (acc && idx < 4) idx++;
        end
        check("burst_accepts", 64'(idx), 64'd4);
        #1;
        check("burst_ack_low", 64'(ack_user2interface), 64'd0);
        check("burst_rx", 64'(rx_count), 64'd4);

        // Simultaneous push and pop from a full FIFO keeps order
        m_axis_tready = 1'b1;
        npop = 0;
        din_interface2user = w[idx];
        tick();
        if (obs_pop) begin got[npop] = obs_data; npop++; end
        #1;
        check("ack_after_pop", 64'(ack_user2interface), 64'd1);
        for (int c = 0; c < 12 && npop < 5; c++) begin
            din_interface2user = w[idx];
            acc = (fifo_q.size() < DEPTH) && vld_interface2user;
            tick();
            if (obs_pop) begin got[npop] = obs_data; npop++; end
            if (acc) begin
                idx++;
                vld_interface2user = 1'b0;
            end
        end
        check("pushpop_count", 64'(npop), 64'd5);
        for (int i = 0; i < 5; i++) check("pushpop_order", 64'(got[i]), 64'(32'h11 + i));

        // Packet framing: pkt_len 3 latched by ap_start, six beats
        vld_interface2user = 1'b0;
        pkt_len = 16'd3;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick(); tick(); tick();
        npop = 0; k = 0;
        for (int c = 0; c < 40 && npop < 6; c++) begin
            vld_interface2user = (k < 6);
            din_interface2user = 32'h30 + k;
            acc = (fifo_q.size() < DEPTH) && vld_interface2user;
            tick();
            if (obs_pop) begin
`ifdef LEAF_AXIS_TLAST_EN
                check("tlast_beat", 64'(obs_last), 64'(((npop + 1) % 3) == 0));
`else
                check("tlast_beat", 64'(obs_last), 64'd0);
`endif
                npop++;
            end
            if (acc) k++;
        end
        vld_interface2user = 1'b0;
        check("tlast_pops", 64'(npop), 64'd6);

        // Transmit backpressure
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hA5; ack_interface2user = 1'b0;
        tick();
        s_axis_tvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_vld", 64'(vld_user2interface), 64'd1);
            check("bp_tready", 64'(s_axis_tready), 64'd0);
            check("bp_dout", 64'(dout_user2interface), 64'hA5);
            tick();
        end
        ack_interface2user = 1'b1;
        #1;
        check("bp_tready_ack", 64'(s_axis_tready), 64'd1);
        tick();
        ack_interface2user = 1'b0;
        #1;
        check("bp_tx", 64'(tx_count), 64'd1);
        check("bp_vld_clear", 64'(vld_user2interface), 64'd0);

        // ap_start flush with two words buffered and a concurrent push
        m_axis_tready = 1'b0;
        vld_interface2user = 1'b1;
        din_interface2user = 32'h41; tick();
        din_interface2user = 32'h42; tick();
        vld_interface2user = 1'b0;
        ap_start = 1'b1;
        tick();
        tick();
        vld_interface2user = 1'b1; din_interface2user = 32'h77;
        tick();
        vld_interface2user = 1'b0;
        #1;
        check("flush_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("flush_rx", 64'(rx_count), 64'd0);
        check("flush_tx", 64'(tx_count), 64'd0);
        check("flush_ack", 64'(ack_user2interface), 64'd1);
        tick();
        ap_start = 1'b0;

        // Reset with FIFO and holding register both full
        vld_interface2user = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hB6;
        for (int c = 0; c < 4; c++) begin
            din_interface2user = 32'h50 + c;
            tick();
        end
        vld_interface2user = 1'b0; s_axis_tvalid = 1'b0;
        #1;
        check("pre_rst_ack", 64'(ack_user2interface), 64'd0);
        check("pre_rst_vld", 64'(vld_user2interface), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_vld", 64'(vld_user2interface), 64'd0);
        check("midrst_s_tready", 64'(s_axis_tready), 64'd1);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            vld_interface2user = ($urandom_range(0, 3) != 0);
            din_interface2user = $urandom;
            m_axis_tready      = ($urandom_range(0, 2) != 0);
            s_axis_tvalid      = ($urandom_range(0, 2) != 0);
            s_axis_tdata       = $urandom;
            ack_interface2user = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 60) == 0) ap_start = ~ap_start;
            pkt_len            = 16'($urandom_range(0, 5));
            reset              = ($urandom_range(0, 700) == 0);
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/leaf_axis_adapter.md
LEAF_AXIS_ADAPTER -- requirements
Module: leaf_axis_adapter

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32: data width of both directions.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries; power of two, minimum 2.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- ap_start  in  1  kernel start level.
- pkt_len  in  16  beats per AXIS packet.
- din_interface2user  in  PAYLOAD_BITS  receive data from the leaf interface.
- vld_interface2user  in  1  receive data valid.
- ack_user2interface  out  1  receive accept.
- m_axis_tdata  out  PAYLOAD_BITS  stream data to the kernel.
- m_axis_tvalid  out  1  stream data valid.
- m_axis_tready  in  1  kernel ready.
- m_axis_tlast  out  1  packet end.
- s_axis_tdata  in  PAYLOAD_BITS  stream data from the kernel.
- s_axis_tvalid  in  1  kernel data valid.
- s_axis_tready  out  1  adapter ready.
- dout_user2interface  out  PAYLOAD_BITS  transmit data to the leaf interface.
- vld_user2interface  out  1  transmit data valid.
- ack_interface2user  in  1  leaf interface accept.
- rx_count  out  32  receive words accepted.
- tx_count  out  32  transmit words delivered.

Function
REQ-004 A receive transfer SHALL occur when vld_interface2user and ack_user2interface are both high in the same cycle; ack_user2interface = (occupancy < FIFO_DEPTH), driven from registered state only.
REQ-005 The receive FIFO SHALL be first-word-fall-through: m_axis_tvalid = (occupancy != 0), and m_axis_tdata = the head entry.
REQ-006 Latency from a receive transfer into an empty FIFO to m_axis_tvalid high SHALL be exactly 1 cycle.
REQ-007 An AXIS pop SHALL occur when m_axis_tvalid and m_axis_tready are both high; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-008 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-009 Occupancy SHALL be log2(FIFO_DEPTH)+1 bits; no overflow or underflow is possible by construction.
REQ-010 The transmit path SHALL be a single holding register with a full flag.
REQ-011 vld_user2interface SHALL equal the full flag, and dout_user2interface SHALL equal the holding register.
REQ-012 s_axis_tready SHALL equal (!full || ack_interface2user); this is a permitted combinational path.
REQ-013 On (s_axis_tvalid && s_axis_tready) the holding register SHALL load s_axis_tdata and the full flag SHALL be set.
REQ-014 On ack_interface2user && full with no load in the same cycle, the full flag SHALL clear.
REQ-015 rx_count SHALL increment once per receive transfer, and tx_count once per (vld_user2interface && ack_interface2user); both SHALL wrap at 2^32.
REQ-016 A rising edge of ap_start SHALL be detected with a 2-flop history, with the flush pulse registered, so the flush occurs 2 cycles after the 0->1 sample.
REQ-017 The flush SHALL clear the FIFO pointers, occupancy, transmit full flag, beat counter, rx_count and tx_count.
REQ-018 The flush SHALL latch pkt_len.
REQ-019 The flush SHALL take priority over any transfer in the same cycle; that transfer is discarded and not counted.

Reset
REQ-020 While reset is high at a clock edge, the following SHALL be 0: all pointers, occupancy, full flag, beat counter, counters, latched pkt_len and ap_start history.
REQ-021 Output values after reset SHALL be: ack_user2interface=1, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=1, vld_user2interface=0, rx_count=0, tx_count=0.
REQ-022 Reset asserted mid-transfer SHALL drop all buffered data without any handshake on either side.

Configuration
REQ-023 With macro LEAF_AXIS_TLAST_EN defined, a 16-bit beat counter SHALL count AXIS pops.
REQ-024 With LEAF_AXIS_TLAST_EN defined, m_axis_tlast = m_axis_tvalid && (beat counter == latched pkt_len - 1).
REQ-025 With LEAF_AXIS_TLAST_EN defined, the counter SHALL return to 0 after a pop with tlast high.
REQ-026 With LEAF_AXIS_TLAST_EN defined, a latched pkt_len of 0 SHALL keep tlast at 0 and let the counter wrap at 2^16.
REQ-027 Without LEAF_AXIS_TLAST_EN, m_axis_tlast SHALL be tied to 0 and no beat counter SHALL exist.

Verification
REQ-028 The bench SHALL cover a receive burst: hold vld high with 5 words 0x11..0x15 and m_axis_tready=0 -> ack drops after 4 accepts; the 5th word is held by the sender; rx_count=4.
REQ-029 The bench SHALL cover simultaneous push/pop: with the FIFO full, raise tready and vld together -> one pop per cycle, ack high the next cycle, data order 0x11..0x15 preserved.
REQ-030 The bench SHALL cover tlast (macro defined): pkt_len=3 latched at ap_start, send 6 words -> tlast high on beats 3 and 6 only.
REQ-031 The bench SHALL cover transmit backpressure: s_axis word 0xA5 with ack=0 for 3 cycles -> vld held, tready=0, and tready=1 in the cycle ack rises; tx_count=1.
REQ-032 The bench SHALL cover the ap_start flush: with 2 words buffered, pulse ap_start 0->1 -> 2 cycles later tvalid=0, counters=0, ack=1, and a concurrent push is dropped.
REQ-033 The bench SHALL cover reset mid-stream: assert reset with the FIFO and holding register full -> the next cycle shows tvalid=0, vld_user2interface=0, s_axis_tready=1.
